keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Sequential scan controller for the 4x4 calculator keypad. It drives the keypad rows one at a time and samples the column lines through a synchroniser. It debounces a single pressed key and presents the key as a one-hot row/column pair that feeds the downstream keypad decoder directly. It emits one strobe per debounced press and a level flag while the key is held.

## Interface
- SCAN_DIV, 1000: clock cycles each row is driven; must be ≥ 4.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required to accept a press and to accept a release; must be ≥ 1.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- col_in  input  4  raw keypad column lines; active-high; asynchronous to clk.
- row_drive  output  4  one-hot row drive to keypad; bit0 = top row.
- key_row  output  4  one-hot row of last accepted key; feeds decoder row.
- key_col  output  4  one-hot column of last accepted key; feeds decoder col.
- key_strobe  output  1  one-cycle pulse when a press is accepted.
- key_held  output  1  high from acceptance until the release is accepted.

## Operation
- col_in passes through a 2-flop synchroniser (col_sync); the FSM uses only col_sync.
- Scan counter runs 0..SCAN_DIV-1 in SCAN.
- States:
  - SCAN
  - DEBOUNCE
  - PRESSED
- SCAN:
  - row_drive rotates 0001→0010→0100→1000→0001. It advances on the edge where the scan counter = SCAN_DIV-1.
  - On that same edge, col_sync is sampled.
  - If exactly one col_sync bit is set: capture cand_row = current row_drive and cand_col = col_sync, go to DEBOUNCE, freeze row_drive (no advance), clear deb_cnt.
  - If zero or ≥2 bits are set: no capture; row advances normally.
- DEBOUNCE:
  - row_drive is held at cand_row.
  - Each edge with col_sync == cand_col increments deb_cnt.
  - Any edge with col_sync ≠ cand_col returns to SCAN. On that edge row_drive advances to the next row and the scan counter clears; no strobe.
  - On the matching edge where deb_cnt = DEBOUNCE_CYCLES-1: key_row ← cand_row, key_col ← cand_col, key_strobe ← 1 for one cycle, key_held ← 1, go to PRESSED, clear deb_cnt.
- PRESSED:
  - row_drive is held at cand_row.
  - Each edge with col_sync ≠ cand_col increments rel_cnt.
  - Any edge with col_sync == cand_col clears rel_cnt.
  - On the mismatching edge where rel_cnt = DEBOUNCE_CYCLES-1: key_held ← 0, go to SCAN. Row advances and the scan counter clears.
  - Extra keys pressed in the same row while held (col_sync superset of cand_col) count as a mismatch.
- key_row/key_col retain the last accepted key until the next acceptance or reset.
- Only one key is reported per press; holding a key never re-strobes.
- Reset values:
  - row_drive = 0001
  - key_row = 0000, key_col = 0000
  - key_strobe = 0, key_held = 0
  - state SCAN
  - scan counter, deb_cnt and rel_cnt = 0
  - synchroniser flops = 0
- Reset asserted in any state, including mid-DEBOUNCE or PRESSED, returns to the reset values on the next edge. The in-progress press is discarded and no strobe is emitted.
- Counter widths: $clog2 of the respective parameter; counters never wrap past their terminal value.

## Timing
- col_in → col_sync latency: 2 cycles.
- Let E0 be the SCAN edge that captures a candidate. key_strobe is high in the cycle following edge E0+DEBOUNCE_CYCLES when all intermediate samples match.
- key_row/key_col update on the same edge that raises key_strobe, so they are valid while key_strobe = 1.
- Release is accepted DEBOUNCE_CYCLES consecutive mismatching samples after the first mismatch. key_held falls on that edge.
- The first row dwell after reset or after a return to SCAN is a full SCAN_DIV cycles.
- Press registered only if col_in is stable ≥ 2 cycles before the sampling edge.
- Full scan period: 4·SCAN_DIV cycles.

## Test plan
- Reset: hold rst 3 cycles with col_in = 1111 → row_drive = 0001, key_row = key_col = 0000, key_strobe = key_held = 0. After release, row_drive cycles 0001→0010→0100→1000 every SCAN_DIV cycles.
- Clean press (SCAN_DIV = 4, DEBOUNCE_CYCLES = 8): model key row1/col2 (col_in = 0100 only while row_drive = 0010) → exactly one key_strobe with key_row = 0010, key_col = 0100, key_held = 1. Release → key_held = 0 after 8 mismatch cycles and scanning resumes at row 0100.
- Bounce: press row3/col0 for 5 cycles, then release → no key_strobe, key_held stays 0, scanning resumes.
- Multi-key: col_in = 0011 during row 0001 → no capture; row_drive advances to 0010.
- Long hold and repress: hold a key for 100 cycles → one strobe only. Release, then press the same key again → second strobe.
- Reset mid-DEBOUNCE: assert rst 3 cycles after capture → no strobe; all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Purpose  : Row-scanning controller for a 4x4 keypad. Drives one row at a
//            time, synchronises the column lines, debounces a single key and
//            reports it as a one-hot row/column pair with a press strobe and
//            a held level.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_drive,
  output logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic       key_strobe,
  output logic       key_held
);

  // Counter widths; a parameter of 1 still needs one bit to hold 0.
  localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [SCW-1:0] SC_LAST = SCW'(SCAN_DIV - 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] S_SCAN     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_PRESSED  = 2'd2;

  logic [3:0]     sync1_q, col_sync_q;
  logic [1:0]     state_q, state_d;
  logic [SCW-1:0] scan_cnt_q, scan_cnt_d;
  logic [DBW-1:0] deb_cnt_q, deb_cnt_d;
  logic [DBW-1:0] rel_cnt_q, rel_cnt_d;
  logic [3:0]     row_q, row_d;
  logic [3:0]     cand_row_q, cand_row_d;
  logic [3:0]     cand_col_q, cand_col_d;
  logic [3:0]     key_row_q, key_row_d;
  logic [3:0]     key_col_q, key_col_d;
  logic           strobe_q, strobe_d;
  logic           held_q, held_d;

  logic           w_one_hot;
  logic           w_match;

  // Next row in the top-to-bottom rotation.
  function automatic logic [3:0] next_row(input logic [3:0] r);
    return {r[2:0], r[3]};
  endfunction

  // Exactly one column active means a single unambiguous key in this row.
  assign w_one_hot = (col_sync_q != 4'b0000) &&
                     ((col_sync_q & (col_sync_q - 4'd1)) == 4'b0000);
  // Any deviation from the candidate column, including extra keys, is a mismatch.
  assign w_match   = (col_sync_q == cand_col_q);

  // Scan / debounce / held state machine next-state logic.
  always_comb begin
    state_d    = state_q;
    scan_cnt_d = scan_cnt_q;
    deb_cnt_d  = deb_cnt_q;
    rel_cnt_d  = rel_cnt_q;
    row_d      = row_q;
    cand_row_d = cand_row_q;
    cand_col_d = cand_col_q;
    key_row_d  = key_row_q;
    key_col_d  = key_col_q;
    strobe_d   = 1'b0;
    held_d     = held_q;
    case (state_q)
      S_SCAN: begin
        if (scan_cnt_q == SC_LAST) begin
          scan_cnt_d = '0;
          if (w_one_hot) begin
            // Freeze on this row and start qualifying the candidate.
            cand_row_d = row_q;
            cand_col_d = col_sync_q;
            deb_cnt_d  = '0;
            state_d    = S_DEBOUNCE;
          end else begin
            row_d = next_row(row_q);
          end
        end else begin
          scan_cnt_d = scan_cnt_q + SCW'(1);
        end
      end
      S_DEBOUNCE: begin
        if (!w_match) begin
          // Bounce: abandon the candidate and continue scanning.
          state_d    = S_SCAN;
          row_d      = next_row(cand_row_q);
          scan_cnt_d = '0;
          deb_cnt_d  = '0;
        end else if (deb_cnt_q == DB_LAST) begin
          key_row_d = cand_row_q;
          key_col_d = cand_col_q;
          strobe_d  = 1'b1;
          held_d    = 1'b1;
          deb_cnt_d = '0;
          rel_cnt_d = '0;
          state_d   = S_PRESSED;
        end else begin
          deb_cnt_d = deb_cnt_q + DBW'(1);
        end
      end
      S_PRESSED: begin
        if (w_match) begin
          rel_cnt_d = '0;
        end else if (rel_cnt_q == DB_LAST) begin
          held_d     = 1'b0;
          state_d    = S_SCAN;
          row_d      = next_row(cand_row_q);
          scan_cnt_d = '0;
          rel_cnt_d  = '0;
        end else begin
          rel_cnt_d = rel_cnt_q + DBW'(1);
        end
      end
      default: begin
        state_d = S_SCAN;
      end
    endcase
  end

  // State registers and the two-flop column synchroniser.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 4'b0000;
      col_sync_q <= 4'b0000;
      state_q    <= S_SCAN;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
      rel_cnt_q  <= '0;
      row_q      <= 4'b0001;
      cand_row_q <= 4'b0000;
      cand_col_q <= 4'b0000;
      key_row_q  <= 4'b0000;
      key_col_q  <= 4'b0000;
      strobe_q   <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      sync1_q    <= col_in;
      col_sync_q <= sync1_q;
      state_q    <= state_d;
      scan_cnt_q <= scan_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
      rel_cnt_q  <= rel_cnt_d;
      row_q      <= row_d;
      cand_row_q <= cand_row_d;
      cand_col_q <= cand_col_d;
      key_row_q  <= key_row_d;
      key_col_q  <= key_col_d;
      strobe_q   <= strobe_d;
      held_q     <= held_d;
    end
  end

  assign row_drive  = row_q;
  assign key_row    = key_row_q;
  assign key_col    = key_col_q;
  assign key_strobe = strobe_q;
  assign key_held   = held_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Purpose  : Self-checking bench for keypad_scanner with a keypad model and a
//            scoreboard of expected accepted keys.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_in;
  logic [3:0] row_drive, key_row, key_col;
  logic       key_strobe, key_held;

  // Keypad model controls
  logic       key_down  = 1'b0;
  logic [3:0] model_row = 4'b0010;
  logic [3:0] model_col = 4'b0100;
  logic       force_en  = 1'b0;
  logic [3:0] force_val = 4'b0000;

  typedef struct packed {
    logic [3:0] row;
    logic [3:0] col;
  } key_t;

  key_t       exp_q[$];
  key_t       mon_exp;
  int         errors = 0;
  int         checks = 0;
  int         strobe_cnt = 0;
  int         s0;
  logic [3:0] t_exp;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
    .clk        (clk),
    .rst        (rst),
    .col_in     (col_in),
    .row_drive  (row_drive),
    .key_row    (key_row),
    .key_col    (key_col),
    .key_strobe (key_strobe),
    .key_held   (key_held)
  );

  always #5 clk = ~clk;

  // Keypad: the pressed key's column is seen only while its row is driven.
  always_comb col_in = force_en ? force_val :
                       ((key_down && (row_drive == model_row)) ? model_col : 4'b0000);

  // Scoreboard: every strobe must match the oldest expected key.
  always @(posedge clk) begin
    #1;
    if (key_strobe === 1'b1) begin
      strobe_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe got row=%b col=%b, expected no strobe", key_row, key_col);
      end else begin
        mon_exp = exp_q.pop_front();
        if (key_row !== mon_exp.row || key_col !== mon_exp.col || key_held !== 1'b1) begin
          errors++;
          $display("FAIL strobe_key got row=%b col=%b held=%b, expected row=%b col=%b held=1",
                   key_row, key_col, key_held, mon_exp.row, mon_exp.col);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input logic [3:0] r, input logic [3:0] c);
    key_t k;
    k.row = r;
    k.col = c;
    exp_q.push_back(k);
  endtask

  task automatic test_reset();
    key_down = 1'b0;
    rst = 1'b1; force_en = 1'b1; force_val = 4'b1111;
    repeat (3) tick();
    checks++; if (row_drive !== 4'b0001) begin errors++; $display("FAIL reset_row got %b expected 0001", row_drive); end
    checks++; if (key_row !== 4'b0000) begin errors++; $display("FAIL reset_key_row got %b expected 0000", key_row); end
    checks++; if (key_col !== 4'b0000) begin errors++; $display("FAIL reset_key_col got %b expected 0000", key_col); end
    checks++; if (key_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b expected 0", key_strobe); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held got %b expected 0", key_held); end
    force_val = 4'b0000;
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      t_exp = 4'b0001 << ((i / SD) % 4);
      checks++;
      if (row_drive !== t_exp) begin
        errors++;
        $display("FAIL scan_rotation edge %0d got %b expected %b", i, row_drive, t_exp);
      end
    end
    force_en = 1'b0;
  endtask

  task automatic test_clean_press();
    s0 = strobe_cnt;
    model_row = 4'b0010; model_col = 4'b0100; key_down = 1'b1;
    rst = 1'b1; repeat (3) tick(); rst = 1'b0;
    push_exp(4'b0010, 4'b0100);
    // Capture on edge 8, acceptance on edge 16.
    repeat (15) tick();
    checks++; if (key_strobe !== 1'b0) begin errors++; $display("FAIL press_early_strobe got %b expected 0", key_strobe); end
    checks++; if (row_drive !== 4'b0010) begin errors++; $display("FAIL press_row_frozen got %b expected 0010", row_drive); end
    tick();
    checks++; if (key_strobe !== 1'b1) begin errors++; $display("FAIL press_strobe_time got %b expected 1", key_strobe); end
    tick();
    checks++; if (key_strobe !== 1'b0 || key_held !== 1'b1) begin errors++; $display("FAIL press_after got strobe=%b held=%b expected 0/1", key_strobe, key_held); end
    repeat (3) tick();
    key_down = 1'b0;
    repeat (9) tick();
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL release_early got held=%b expected 1", key_held); end
    tick();
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL release_time got held=%b expected 0", key_held); end
    checks++; if (row_drive !== 4'b0100) begin errors++; $display("FAIL release_row got %b expected 0100", row_drive); end
    checks++; if (strobe_cnt - s0 != 1) begin errors++; $display("FAIL press_strobe_count got %0d expected 1", strobe_cnt - s0); end
  endtask

  task automatic test_bounce();
    s0 = strobe_cnt;
    model_row = 4'b1000; model_col = 4'b0001; key_down = 1'b1;
    rst = 1'b1; repeat (3) tick(); rst = 1'b0;
    repeat (16) tick();
    checks++; if (row_drive !== 4'b1000) begin errors++; $display("FAIL bounce_capture got row %b expected 1000", row_drive); end
    repeat (5) tick();
    key_down = 1'b0;
    repeat (3) tick();
    checks++; if (row_drive !== 4'b0001) begin errors++; $display("FAIL bounce_resume got row %b expected 0001", row_drive); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL bounce_held got %b expected 0", key_held); end
    repeat (SD) tick();
    checks++; if (row_drive !== 4'b0010) begin errors++; $display("FAIL bounce_scan got row %b expected 0010", row_drive); end
    checks++; if (strobe_cnt != s0) begin errors++; $display("FAIL bounce_strobes got %0d expected 0", strobe_cnt - s0); end
  endtask

  task automatic test_multi_key();
    s0 = strobe_cnt;
    key_down = 1'b0;
    rst = 1'b1; force_en = 1'b1; force_val = 4'b0011;
    repeat (3) tick(); rst = 1'b0;
    repeat (SD) tick();
    checks++; if (row_drive !== 4'b0010) begin errors++; $display("FAIL multi_row1 got %b expected 0010", row_drive); end
    repeat (SD) tick();
    checks++; if (row_drive !== 4'b0100) begin errors++; $display("FAIL multi_row2 got %b expected 0100", row_drive); end
    checks++; if (strobe_cnt != s0) begin errors++; $display("FAIL multi_strobes got %0d expected 0", strobe_cnt - s0); end
    force_en = 1'b0; force_val = 4'b0000;
  endtask

  task automatic test_long_hold_repress();
    s0 = strobe_cnt;
    model_row = 4'b0010; model_col = 4'b0100; key_down = 1'b1;
    rst = 1'b1; repeat (3) tick(); rst = 1'b0;
    push_exp(4'b0010, 4'b0100);
    for (int i = 0; i < 100 && strobe_cnt == s0; i++) tick();
    checks++; if (strobe_cnt == s0) begin errors++; $display("FAIL hold_first_timeout got no strobe expected 1"); end
    repeat (100) tick();
    checks++; if (strobe_cnt - s0 != 1 || key_held !== 1'b1) begin errors++; $display("FAIL hold_single got strobes=%0d held=%b expected 1/1", strobe_cnt - s0, key_held); end
    key_down = 1'b0;
    for (int i = 0; i < 50 && key_held !== 1'b0; i++) tick();
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL hold_release_timeout got held=%b expected 0", key_held); end
    push_exp(4'b0010, 4'b0100);
    key_down = 1'b1;
    for (int i = 0; i < 200 && strobe_cnt - s0 < 2; i++) tick();
    checks++; if (strobe_cnt - s0 != 2) begin errors++; $display("FAIL repress_timeout got strobes=%0d expected 2", strobe_cnt - s0); end
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL repress_held got %b expected 1", key_held); end
  endtask

  task automatic test_reset_mid_debounce();
    s0 = strobe_cnt;
    key_down = 1'b0;
    for (int i = 0; i < 50 && key_held !== 1'b0; i++) tick();
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL mid_release_timeout got held=%b expected 0", key_held); end
    key_down = 1'b1;
    for (int i = 0; i < 50 && row_drive !== 4'b0010; i++) tick();
    checks++; if (row_drive !== 4'b0010) begin errors++; $display("FAIL mid_row_timeout got %b expected 0010", row_drive); end
    repeat (SD + 3) tick();
    checks++; if (row_drive !== 4'b0010) begin errors++; $display("FAIL mid_capture got row %b expected 0010", row_drive); end
    rst = 1'b1;
    tick();
    checks++; if (row_drive !== 4'b0001) begin errors++; $display("FAIL mid_reset_row got %b expected 0001", row_drive); end
    checks++; if (key_row !== 4'b0000 || key_col !== 4'b0000) begin errors++; $display("FAIL mid_reset_key got row=%b col=%b expected 0000/0000", key_row, key_col); end
    checks++; if (key_strobe !== 1'b0 || key_held !== 1'b0) begin errors++; $display("FAIL mid_reset_flags got strobe=%b held=%b expected 0/0", key_strobe, key_held); end
    key_down = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (20) tick();
    checks++; if (strobe_cnt != s0) begin errors++; $display("FAIL mid_reset_strobes got %0d expected 0", strobe_cnt - s0); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi_key();
    test_long_hold_repress();
    test_reset_mid_debounce();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
